// File: rtl/cache_arbiter_pkg.sv
// Shared cache package: FSM state encoding, default parameter values,
// the latched-operation payload and a width helper for the D streak counter.
package cache_arbiter_pkg;

    localparam int unsigned DEF_WORD_SIZE    = 16;
    localparam int unsigned DEF_STARVE_LIMIT = 3;
    localparam int unsigned DEF_MIN_WAIT     = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    // Operation captured at grant time and held until the transaction ends.
    typedef struct packed {
        logic owner_d;
        logic is_wr;
    } req_op_t;

    // Bits needed to count 0..limit (at least one bit).
    function automatic int unsigned streak_width(input int unsigned limit);
        int unsigned w;
        w = 1;
        while ((1 << w) <= limit) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/cache_arbiter_arb_select.sv
// arb_select: D-favouring grant selection with an anti-starvation streak
// counter for the I port.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   i_ireq         instruction-fetch request pending
//   i_dreq         data request (read or write) pending
//   i_grant_en     a grant is taken this cycle if any request is present
//   o_any_req_c    combinational: some request is present
//   o_grant_d_c    combinational: D wins the current arbitration
module arb_select
    import cache_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_ireq,
    input  logic i_dreq,
    input  logic i_grant_en,
    output logic o_any_req_c,
    output logic o_grant_d_c
);

    localparam int unsigned     SW    = streak_width(STARVE_LIMIT);
    localparam logic [SW-1:0]   LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0] r_d_streak;
    logic          w_starved;

    // I has waited through the maximum run of D grants.
    assign w_starved   = i_ireq && (r_d_streak == LIMIT);
    assign o_any_req_c = i_ireq || i_dreq;
    assign o_grant_d_c = i_dreq && !w_starved;

    // Streak counts D grants made while I was waiting; any other grant clears it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_d_streak <= '0;
        end else if (i_grant_en && o_any_req_c) begin
            if (o_grant_d_c && i_ireq) begin
                if (r_d_streak != LIMIT) begin
                    r_d_streak <= r_d_streak + SW'(1);
                end
            end else begin
                r_d_streak <= '0;
            end
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one cache request port between an instruction-fetch
// port (I) and a data port (D). One transaction at a time:
// IDLE -> ISSUE (one-cycle strobe) -> WAIT (>= MIN_WAIT cycles, until the
// cache is not busy) -> DONE (one-cycle ack) -> IDLE.
// Ports:
//   clk, reset_n                        clock, synchronous active-low reset
//   i_req, i_addr / i_ack, i_rdata      I port request and completion
//   d_rd_req, d_wr_req, d_addr, d_wdata D port request
//   d_ack, d_rdata                      D port completion
//   cache_read_req, cache_write_req     cache strobes (ISSUE cycle only)
//   req_addr, req_data                  latched cache address / write data
//   is_cache_processing, resultData     cache busy flag and read data
//   owner_d                             current grant belongs to D
//   i_grant_cnt, d_grant_cnt            wrapping grant counters
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int unsigned WORD_SIZE    = DEF_WORD_SIZE,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int unsigned MIN_WAIT     = DEF_MIN_WAIT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic                 i_ack,
    output logic [WORD_SIZE-1:0] i_rdata,
    input  logic                 d_rd_req,
    input  logic                 d_wr_req,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_ack,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 cache_read_req,
    output logic                 cache_write_req,
    output logic [WORD_SIZE-1:0] req_addr,
    output logic [WORD_SIZE-1:0] req_data,
    input  logic                 is_cache_processing,
    input  logic [WORD_SIZE-1:0] resultData,
    output logic                 owner_d,
    output logic [WORD_SIZE-1:0] i_grant_cnt,
    output logic [WORD_SIZE-1:0] d_grant_cnt
);

    localparam int unsigned       WAIT_W   = 16;
    localparam logic [WAIT_W-1:0] WAIT_THR = WAIT_W'((MIN_WAIT > 0) ? (MIN_WAIT - 1) : 0);

    arb_state_e           r_state;
    req_op_t              r_op;
    logic [WAIT_W-1:0]    r_wait_cnt;
    logic [WORD_SIZE-1:0] r_req_addr;
    logic [WORD_SIZE-1:0] r_req_data;
    logic                 r_cache_rd;
    logic                 r_cache_wr;
    logic                 r_i_ack;
    logic                 r_d_ack;
    logic [WORD_SIZE-1:0] r_i_rdata;
    logic [WORD_SIZE-1:0] r_d_rdata;
    logic [WORD_SIZE-1:0] r_i_cnt;
    logic [WORD_SIZE-1:0] r_d_cnt;

    logic w_any_req;
    logic w_grant_d;
    logic w_grant_en;
    logic w_wait_done;

    assign w_grant_en  = (r_state == ST_IDLE);
    assign w_wait_done = (r_wait_cnt >= WAIT_THR) && !is_cache_processing;

    arb_select #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_ireq      (i_req),
        .i_dreq      (d_rd_req || d_wr_req),
        .i_grant_en  (w_grant_en),
        .o_any_req_c (w_any_req),
        .o_grant_d_c (w_grant_d)
    );

    // Transaction FSM with registered strobes, acks, read data and counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_op       <= '0;
            r_wait_cnt <= '0;
            r_req_addr <= '0;
            r_req_data <= '0;
            r_cache_rd <= 1'b0;
            r_cache_wr <= 1'b0;
            r_i_ack    <= 1'b0;
            r_d_ack    <= 1'b0;
            r_i_rdata  <= '0;
            r_d_rdata  <= '0;
            r_i_cnt    <= '0;
            r_d_cnt    <= '0;
        end else begin
            // Strobes and acks are single-cycle pulses.
            r_cache_rd <= 1'b0;
            r_cache_wr <= 1'b0;
            r_i_ack    <= 1'b0;
            r_d_ack    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_op.owner_d <= w_grant_d;
                        if (w_grant_d) begin
                            // Simultaneous read and write is taken as a write.
                            r_op.is_wr <= d_wr_req;
                            r_req_addr <= d_addr;
                            r_req_data <= d_wdata;
                            r_cache_rd <= !d_wr_req;
                            r_cache_wr <= d_wr_req;
                            r_d_cnt    <= r_d_cnt + WORD_SIZE'(1);
                        end else begin
                            r_op.is_wr <= 1'b0;
                            r_req_addr <= i_addr;
                            r_req_data <= '0;
                            r_cache_rd <= 1'b1;
                            r_i_cnt    <= r_i_cnt + WORD_SIZE'(1);
                        end
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_wait_cnt <= '0;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_wait_cnt != '1) begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                    if (w_wait_done) begin
                        r_state <= ST_DONE;
                        if (r_op.owner_d) begin
                            r_d_ack <= 1'b1;
                            if (!r_op.is_wr) begin
                                r_d_rdata <= resultData;
                            end
                        end else begin
                            r_i_ack <= 1'b1;
                            if (!r_op.is_wr) begin
                                r_i_rdata <= resultData;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign i_ack           = r_i_ack;
    assign d_ack           = r_d_ack;
    assign i_rdata         = r_i_rdata;
    assign d_rdata         = r_d_rdata;
    assign cache_read_req  = r_cache_rd;
    assign cache_write_req = r_cache_wr;
    assign req_addr        = r_req_addr;
    assign req_data        = r_req_data;
    assign owner_d         = r_op.owner_d;
    assign i_grant_cnt     = r_i_cnt;
    assign d_grant_cnt     = r_d_cnt;

endmodule

// File: tb/tb_cache_arbiter.sv
// Testbench for cache_arbiter: directed and randomized transactions checked
// against a transaction-level reference model (winner rule, latency formula,
// expected data and counters). A narrow second instance exercises counter wrap.
module tb_cache_arbiter;

    localparam int unsigned SL = 3;
    localparam int unsigned MW = 2;

    logic        clk;
    logic        reset_n;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_ack;
    logic [15:0] i_rdata;
    logic        d_rd_req;
    logic        d_wr_req;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic        cache_read_req;
    logic        cache_write_req;
    logic [15:0] req_addr;
    logic [15:0] req_data;
    logic        is_cache_processing;
    logic [15:0] resultData;
    logic        owner_d;
    logic [15:0] i_grant_cnt;
    logic [15:0] d_grant_cnt;

    // Narrow instance signals
    logic       n_i_ack, n_d_ack, n_rd, n_wr, n_owner;
    logic       n_d_rd_req;
    logic [3:0] n_i_rdata, n_d_rdata, n_addr, n_data, n_icnt, n_dcnt;

    int unsigned n_vec;
    int unsigned n_err;

    // Reference model state
    int unsigned m_streak;
    int unsigned m_icnt;
    int unsigned m_dcnt;
    logic [15:0] m_irdata;
    logic [15:0] m_drdata;

    cache_arbiter #(
        .WORD_SIZE(16), .STARVE_LIMIT(SL), .MIN_WAIT(MW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .cache_read_req(cache_read_req), .cache_write_req(cache_write_req),
        .req_addr(req_addr), .req_data(req_data),
        .is_cache_processing(is_cache_processing), .resultData(resultData),
        .owner_d(owner_d), .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
    );

    cache_arbiter #(
        .WORD_SIZE(4), .STARVE_LIMIT(SL), .MIN_WAIT(MW)
    ) dut_w (
        .clk(clk), .reset_n(reset_n),
        .i_req(1'b0), .i_addr(4'h0), .i_ack(n_i_ack), .i_rdata(n_i_rdata),
        .d_rd_req(n_d_rd_req), .d_wr_req(1'b0), .d_addr(4'h5), .d_wdata(4'h0),
        .d_ack(n_d_ack), .d_rdata(n_d_rdata),
        .cache_read_req(n_rd), .cache_write_req(n_wr),
        .req_addr(n_addr), .req_data(n_data),
        .is_cache_processing(1'b0), .resultData(4'hA),
        .owner_d(n_owner), .i_grant_cnt(n_icnt), .d_grant_cnt(n_dcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction, entered #1 after an edge in an IDLE cycle; returns in
    // the IDLE cycle that follows DONE.
    task automatic do_txn(input bit ir, input bit drd, input bit dwr,
                          input logic [15:0] ia, input logic [15:0] da,
                          input logic [15:0] wd, input int unsigned busy_n,
                          input bit hold, output bit obs_owner);
        bit          gd;
        bit          wr;
        logic [15:0] exp_addr;
        logic [15:0] rd_val;
        int unsigned exit_k;

        // Reference: D wins unless I has watched SL D grants in a row.
        gd = (drd || dwr) && !(ir && (m_streak == SL));
        wr = gd && dwr;
        exp_addr = gd ? da : ia;
        if (gd && ir) m_streak = (m_streak < SL) ? m_streak + 1 : m_streak;
        else          m_streak = 0;
        if (gd) m_dcnt = (m_dcnt + 1) % 65536;
        else    m_icnt = (m_icnt + 1) % 65536;
        exit_k = ((MW > 0) ? MW - 1 : 0);
        if (busy_n > exit_k) exit_k = busy_n;

        i_req = ir; d_rd_req = drd; d_wr_req = dwr;
        i_addr = ia; d_addr = da; d_wdata = wd;
        is_cache_processing = 1'b0;

        tick();  // ISSUE
        obs_owner = owner_d;
        check("issue_rd", 32'(cache_read_req), 32'(!wr));
        check("issue_wr", 32'(cache_write_req), 32'(wr));
        check("owner", 32'(owner_d), 32'(gd));
        check("req_addr", 32'(req_addr), 32'(exp_addr));
        if (wr) check("req_data", 32'(req_data), 32'(wd));
        check("i_cnt", 32'(i_grant_cnt), m_icnt);
        check("d_cnt", 32'(d_grant_cnt), m_dcnt);
        check("streak", 32'(dut.u_arb.r_d_streak), m_streak);

        tick();  // WAIT cycle 0
        rd_val = '0;
        for (int unsigned k = 0; k <= exit_k; k++) begin
            check("strobe_off", 32'({cache_read_req, cache_write_req}), 32'(0));
            check("no_ack", 32'({i_ack, d_ack}), 32'(0));
            is_cache_processing = (k < busy_n);
            resultData = 16'($urandom);
            rd_val = resultData;
            // Request-side changes outside IDLE must have no effect.
            i_addr = 16'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
            tick();
        end

        // DONE
        is_cache_processing = 1'b0;
        if (!wr) begin
            if (gd) m_drdata = rd_val;
            else    m_irdata = rd_val;
        end
        check("ack", 32'({i_ack, d_ack}), gd ? 32'h1 : 32'h2);
        check("i_rdata", 32'(i_rdata), 32'(m_irdata));
        check("d_rdata", 32'(d_rdata), 32'(m_drdata));
        check("hold_addr", 32'(req_addr), 32'(exp_addr));
        if (wr) check("hold_data", 32'(req_data), 32'(wd));
        check("done_strobe", 32'({cache_read_req, cache_write_req}), 32'(0));
        if (!hold) begin
            i_req = 1'b0; d_rd_req = 1'b0; d_wr_req = 1'b0;
        end
        resultData = 16'($urandom);

        tick();  // IDLE
        check("ack_clr", 32'({i_ack, d_ack}), 32'(0));
    endtask

    initial begin
        bit          ob;
        logic [2:0]  r;
        logic [7:0]  pat;

        n_vec = 0; n_err = 0;
        m_streak = 0; m_icnt = 0; m_dcnt = 0; m_irdata = '0; m_drdata = '0;
        reset_n = 1'b0;
        i_req = 1'b0; i_addr = '0; d_rd_req = 1'b0; d_wr_req = 1'b0;
        d_addr = '0; d_wdata = '0; is_cache_processing = 1'b0;
        resultData = 16'h5A5A; n_d_rd_req = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_acks", 32'({i_ack, d_ack}), 32'(0));
        check("rst_strobes", 32'({cache_read_req, cache_write_req}), 32'(0));
        check("rst_addr_data", {req_addr, req_data}, 32'(0));
        check("rst_rdata", {i_rdata, d_rdata}, 32'(0));
        check("rst_cnts", {i_grant_cnt, d_grant_cnt}, 32'(0));
        check("rst_owner", 32'(owner_d), 32'(0));
        reset_n = 1'b1;

        // No request: block stays idle.
        repeat (3) begin
            tick();
            check("idle_strobes", 32'({cache_read_req, cache_write_req}), 32'(0));
        end

        // I read hit at 0x0040.
        do_txn(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0, 16'h0, 0, 1'b0, ob);
        check("i_hit_cnt", 32'(i_grant_cnt), 32'(1));

        // D write 0x0013 / 0xBEEF with a 6-cycle miss.
        do_txn(1'b0, 1'b0, 1'b1, 16'h0, 16'h0013, 16'hBEEF, 6, 1'b0, ob);

        // Read and write together act as a write.
        do_txn(1'b0, 1'b1, 1'b1, 16'h0, 16'h0077, 16'h1234, 1, 1'b0, ob);

        // Randomized mix, with occasional idle cycles.
        for (int t = 0; t < 60; t++) begin
            r = 3'($urandom);
            if (r == 3'b000) begin
                tick();
                check("rnd_idle", 32'({cache_read_req, cache_write_req, i_ack, d_ack}), 32'(0));
            end else begin
                do_txn(r[0], r[1], r[2], 16'($urandom), 16'($urandom), 16'($urandom),
                       $urandom_range(0, 4), 1'b0, ob);
            end
        end

        // Reset in the middle of a miss.
        i_req = 1'b0; d_rd_req = 1'b1; d_addr = 16'h1234;
        tick();  // ISSUE
        tick();  // WAIT
        is_cache_processing = 1'b1;
        repeat (3) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1; d_rd_req = 1'b0; is_cache_processing = 1'b0;
        m_streak = 0; m_icnt = 0; m_dcnt = 0; m_irdata = '0; m_drdata = '0;
        check("mid_rst_strobes", 32'({cache_read_req, cache_write_req}), 32'(0));
        check("mid_rst_cnts", {i_grant_cnt, d_grant_cnt}, 32'(0));
        check("mid_rst_owner", 32'(owner_d), 32'(0));
        check("mid_rst_addr", 32'(req_addr), 32'(0));
        repeat (6) begin
            tick();
            check("mid_rst_no_ack", 32'({i_ack, d_ack}), 32'(0));
        end

        // Both ports held: D,D,D,I,D,D,D,I.
        pat = 8'b0111_0111;
        for (int j = 0; j < 8; j++) begin
            do_txn(1'b1, 1'b1, 1'b0, 16'(16'h0100 + j), 16'(16'h0200 + j), 16'h0,
                   $urandom_range(0, 2), (j != 7), ob);
            check("held_order", 32'(ob), 32'(pat[j]));
        end

        // Counter wrap on the 4-bit instance.
        n_d_rd_req = 1'b1;
        for (int g = 1; g <= 17; g++) begin
            tick();
            check("wrap_cnt", 32'(n_dcnt), 32'(g % 16));
            repeat (4) tick();
        end
        n_d_rd_req = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
